multicycle_multiplier: RTL

MULTICYCLE_MULTIPLIER -- requirements
Module: multicycle_multiplier

---
 rtl/mul_pkg.sv | 41 ++++
 rtl/mul_step.sv | 28 ++
 rtl/multicycle_multiplier.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multicycle multiplier: command encodings,
// FSM state encoding and small command-decode helpers.
// Imported by multicycle_multiplier and mul_step.
package mul_pkg;

    localparam logic [2:0] CMD_MUL   = 3'b000;
    localparam logic [2:0] CMD_MLA   = 3'b001;
    localparam logic [2:0] CMD_UMULL = 3'b100;
    localparam logic [2:0] CMD_UMLAL = 3'b101;
    localparam logic [2:0] CMD_SMULL = 3'b110;
    localparam logic [2:0] CMD_SMLAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Command produces a 2*WIDTH result (aux carries the high half)
    function automatic logic is_long(input logic [2:0] cmd);
        return (cmd == CMD_UMULL) || (cmd == CMD_UMLAL) ||
               (cmd == CMD_SMULL) || (cmd == CMD_SMLAL);
    endfunction

    // Operands are two's-complement
    function automatic logic is_signed(input logic [2:0] cmd);
        return (cmd == CMD_SMULL) || (cmd == CMD_SMLAL);
    endfunction

    // Command adds an accumulator after the product
    function automatic logic is_acc(input logic [2:0] cmd);
        return (cmd == CMD_MLA) || (cmd == CMD_UMLAL) || (cmd == CMD_SMLAL);
    endfunction

    // 010/011 are reserved and complete immediately with a zero result
    function automatic logic is_valid(input logic [2:0] cmd);
        return (cmd == CMD_MUL) || (cmd == CMD_MLA) || is_long(cmd);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PER_CYCLE partial-product accumulate: sum = acc + mcand*digit.
// Purely combinational; mcand arrives pre-shifted to the current digit weight.
// No handshake; the caller registers the sum.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] digit_i,
    output logic [2*WIDTH-1:0]        sum_o
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] digit_ext;
    logic [PW-1:0] partial;

    // Partial product truncated to the accumulator width (modulo 2^PW)
    always_comb begin
        digit_ext = {{(PW-BITS_PER_CYCLE){1'b0}}, digit_i};
        partial   = mcand_i * digit_ext;
        sum_o     = acc_i + partial;
    end

endmodule

// File: rtl/multicycle_multiplier.sv
// Iterative WIDTH x WIDTH multiplier (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), BITS_PER_CYCLE per step.
// Latency N+2 cycles from accepted start to done (N = WIDTH/BITS_PER_CYCLE); reserved cmds: 1 cycle.
// Optional MUL_EARLY_TERM_EN: leave CALC once remaining multiplier bits are zero. Start ignored while busy.
module multicycle_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       mul_cmd,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] aux
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    addend_q;
    logic [WIDTH-1:0] mplier_q;
    logic             neg_q;
    logic             short_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] aux_q;

    logic [WIDTH-1:0] rn_mag;
    logic [WIDTH-1:0] rm_mag;
    logic [PW-1:0]    addend_d;
    logic [PW-1:0]    step_sum;
    logic [WIDTH-1:0] mplier_d;
    logic [PW-1:0]    result_d;
    logic             calc_last;

    // Operand conditioning at acceptance: magnitudes for signed commands
    // (-2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude)
    always_comb begin
        rn_mag   = rn;
        rm_mag   = rm;
        addend_d = '0;
        if (is_signed(mul_cmd)) begin
            if (rn[WIDTH-1]) rn_mag = -rn;
            if (rm[WIDTH-1]) rm_mag = -rm;
        end
        if (is_acc(mul_cmd)) begin
            addend_d = is_long(mul_cmd) ? {rd, ra} : {{WIDTH{1'b0}}, ra};
        end
    end

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .sum_o   (step_sum)
    );

    // Next multiplier, last-iteration decision and sign/accumulate fix-up
    always_comb begin
        mplier_d  = mplier_q >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_TERM_EN
        calc_last = (cnt_q == CW'(1)) || (mplier_d == '0);
`else
        calc_last = (cnt_q == CW'(1));
`endif
        result_d  = (neg_q ? -acc_q : acc_q) + addend_q;
    end

    // Control FSM and datapath registers; flush wins over everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            addend_q <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            short_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            aux_q    <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (!is_valid(mul_cmd)) begin
                            y_q     <= '0;
                            aux_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            mcand_q  <= {{WIDTH{1'b0}}, rn_mag};
                            mplier_q <= rm_mag;
                            neg_q    <= is_signed(mul_cmd) & (rn[WIDTH-1] ^ rm[WIDTH-1]);
                            short_q  <= ~is_long(mul_cmd);
                            addend_q <= addend_d;
                            acc_q    <= '0;
                            cnt_q    <= CW'(N);
                            state_q  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q    <= step_sum;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (calc_last) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    y_q     <= result_d[WIDTH-1:0];
                    aux_q   <= short_q ? '0 : result_d[PW-1:WIDTH];
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign aux  = aux_q;

endmodule
